// File: rtl/inst_realign_pkg.sv
// Shared constants and helpers for the fetch realignment slice.
//   HW_C_MASK : low two bits of a halfword that mark a 32-bit instruction
//   FETCH_W   : width of one aligned fetch word
//   hw_is_c   : 1 when a halfword starts a compressed instruction
package inst_realign_pkg;

    localparam logic [1:0]  HW_C_MASK = 2'b11;
    localparam int unsigned FETCH_W   = 32;

    function automatic logic hw_is_c(input logic [15:0] hw);
        return hw[1:0] != HW_C_MASK;
    endfunction

endpackage

// File: rtl/inst_hw_queue.sv
// DEPTH-entry circular FIFO of {halfword, pc} pairs.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : empty the queue and zero both pointers
//   push1 / push2     : write one entry (hw0) or two entries (hw0, hw1)
//   push_hw*/push_pc* : data for the pushed entries, hw0 is written first
//   pop1 / pop2       : retire one or two entries from the head
//   head0_* / head1_* : entries at rd_ptr and rd_ptr+1
//   count             : number of valid entries, 0..DEPTH
module inst_hw_queue #(
    parameter int unsigned PC_WIDTH = 64,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push1,
    input  logic                push2,
    input  logic [15:0]         push_hw0,
    input  logic [PC_WIDTH-1:0] push_pc0,
    input  logic [15:0]         push_hw1,
    input  logic [PC_WIDTH-1:0] push_pc1,
    input  logic                pop1,
    input  logic                pop2,
    output logic [15:0]         head0_hw,
    output logic [PC_WIDTH-1:0] head0_pc,
    output logic [15:0]         head1_hw,
    output logic [CNT_W-1:0]    count
);

    logic [15:0]         hw_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    push_n;
    logic [CNT_W-1:0]    pop_n;

    // push1/push2 and pop1/pop2 are mutually exclusive, so the pair reads as a count
    assign push_n = CNT_W'({push2, push1});
    assign pop_n  = CNT_W'({pop2, pop1});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hw_mem[i] <= '0;
                pc_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push1 || push2) begin
                hw_mem[wr_ptr] <= push_hw0;
                pc_mem[wr_ptr] <= push_pc0;
            end
            if (push2) begin
                hw_mem[wr_ptr + PTR_W'(1)] <= push_hw1;
                pc_mem[wr_ptr + PTR_W'(1)] <= push_pc1;
            end
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count  <= count + push_n - pop_n;
        end
    end

    assign head0_hw = hw_mem[rd_ptr];
    assign head0_pc = pc_mem[rd_ptr];
    assign head1_hw = hw_mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/inst_realign.sv
// Fetch-side realignment buffer: splits aligned 32-bit fetch words into
// halfwords and emits one whole instruction (16- or 32-bit) per cycle.
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : redirect, drop everything buffered
//   fetch_valid/ready     : fetch word handshake
//   fetch_data, fetch_pc  : fetch word and its PC (pc[1]=1: only [31:16] live)
//   out_valid/ready       : instruction handshake
//   out_inst, out_is_c    : raw instruction, compressed flag
//   out_pc                : PC of the instruction's first halfword
module inst_realign
    import inst_realign_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 64,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                fetch_valid,
    output logic                fetch_ready,
    input  logic [FETCH_W-1:0]  fetch_data,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic                out_is_c,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]    count;
    logic [15:0]         head0_hw;
    logic [15:0]         head1_hw;
    logic [PC_WIDTH-1:0] head0_pc;
    logic                odd;
    logic                accept;
    logic                push1;
    logic                push2;
    logic [15:0]         push_hw0;
    logic [PC_WIDTH-1:0] push_pc0;
    logic [PC_WIDTH-1:0] push_pc1;
    logic                is_c;
    logic                pop;
    logic                unused_pc0;

    assign unused_pc0 = fetch_pc[0];

    // Space check uses the registered count only; a same-cycle pop does not help
    assign fetch_ready = (DEPTH_C - count) >= CNT_W'(2);
    assign accept      = fetch_valid && fetch_ready && !flush;
    assign odd         = fetch_pc[1];
    assign push1       = accept && odd;
    assign push2       = accept && !odd;
    assign push_hw0    = odd ? fetch_data[31:16] : fetch_data[15:0];
    assign push_pc0    = {fetch_pc[PC_WIDTH-1:2], odd, 1'b0};
    assign push_pc1    = {fetch_pc[PC_WIDTH-1:2], 2'b10};

    inst_hw_queue #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push1    (push1),
        .push2    (push2),
        .push_hw0 (push_hw0),
        .push_pc0 (push_pc0),
        .push_hw1 (fetch_data[31:16]),
        .push_pc1 (push_pc1),
        .pop1     (pop && is_c),
        .pop2     (pop && !is_c),
        .head0_hw (head0_hw),
        .head0_pc (head0_pc),
        .head1_hw (head1_hw),
        .count    (count)
    );

    assign is_c      = hw_is_c(head0_hw);
    assign out_valid = !flush && (count != '0) && (is_c || count >= CNT_W'(2));
    assign pop       = out_valid && out_ready;

    // Entries reset to zero, so out_inst/out_pc read 0 while empty after reset;
    // the count gate keeps out_is_c at 0 there as well.
    assign out_inst  = is_c ? {16'h0, head0_hw} : {head1_hw, head0_hw};
    assign out_is_c  = is_c && (count != '0);
    assign out_pc    = head0_pc;

endmodule

// File: tb/tb_inst_realign.sv
module tb_inst_realign;

    localparam int unsigned PCW   = 64;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_data;
    logic [PCW-1:0]  fetch_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic            out_is_c;
    logic [PCW-1:0]  out_pc;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference model: the buffered halfwords in program order
    logic [15:0]    hw_q [$];
    logic [PCW-1:0] pc_q [$];

    inst_realign #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .fetch_pc    (fetch_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_is_c    (out_is_c),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge
    task automatic step(input logic fv, input logic [31:0] fd, input logic [PCW-1:0] fpc,
                        input logic ordy, input logic fl);
        logic            e_ready, e_valid, e_c;
        logic [31:0]     e_inst;
        int unsigned     n;
        fetch_valid = fv;
        fetch_data  = fd;
        fetch_pc    = fpc;
        out_ready   = ordy;
        flush       = fl;
        #4;
        n       = hw_q.size();
        e_ready = (DEPTH - n) >= 2;
        e_c     = (n > 0) && (hw_q[0][1:0] != 2'b11);
        // A full instruction is present when a compressed head is buffered, or both halves of a 32-bit one
        e_valid = !fl && ((n >= 1 && e_c) || (n >= 2 && !e_c));
        chk("fetch_ready", 64'(fetch_ready), 64'(e_ready));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        if (e_valid) begin
            e_inst = e_c ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
            chk("out_inst", 64'(out_inst), 64'(e_inst));
            chk("out_is_c", 64'(out_is_c), 64'(e_c));
            chk("out_pc", out_pc, pc_q[0]);
        end
        @(posedge clk);
        if (fl) begin
            hw_q.delete();
            pc_q.delete();
        end else begin
            if (e_valid && ordy) begin
                void'(hw_q.pop_front()); void'(pc_q.pop_front());
                if (!e_c) begin
                    void'(hw_q.pop_front()); void'(pc_q.pop_front());
                end
            end
            if (fv && e_ready) begin
                if (fpc[1]) begin
                    hw_q.push_back(fd[31:16]); pc_q.push_back({fpc[PCW-1:2], 2'b10});
                end else begin
                    hw_q.push_back(fd[15:0]);  pc_q.push_back({fpc[PCW-1:2], 2'b00});
                    hw_q.push_back(fd[31:16]); pc_q.push_back({fpc[PCW-1:2], 2'b10});
                end
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready"}, 64'(fetch_ready), 64'd1);
        chk({tag, "_inst"}, 64'(out_inst), 64'd0);
        chk({tag, "_is_c"}, 64'(out_is_c), 64'd0);
        chk({tag, "_pc"}, out_pc, 64'd0);
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        return h;
    endfunction

    initial begin
        logic [PCW-1:0] rpc;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
        fetch_pc = '0; out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Two compressed halves of one word
        step(1, 32'h0001_4501, 64'h8000_0000, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Aligned 32-bit instruction
        step(1, 32'h0000_0513, 64'h1000, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Straddling 32-bit instruction across two words
        step(1, 32'h0513_4501, 64'h2000, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(1, 32'h4505_0000, 64'h2004, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Redirect to the odd halfword
        step(1, 32'h4585_FFFF, 64'h3002, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Backpressure: fill to DEPTH, then drain with continuous fetches
        step(1, 32'h4505_4501, 64'h4000, 0, 0);
        step(1, 32'h4515_4511, 64'h4004, 0, 0);
        step(1, 32'h4525_4521, 64'h4008, 0, 0);
        step(1, 32'h4525_4521, 64'h4008, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h4535_4531 + 32'(i), 64'h4008 + 64'(4 * i), 1, 0);
        for (int i = 0; i < 6; i++) step(0, 32'h0, 64'h0, 1, 0);

        // Flush at count 3 with a fetch offered in the same cycle
        step(1, 32'h4545_4541, 64'h5002, 0, 0);
        step(1, 32'h4555_4551, 64'h5004, 0, 0);
        step(1, 32'h4565_4561, 64'h5008, 1, 1);
        step(0, 32'h0, 64'h0, 1, 0);
        step(1, 32'h4575_4571, 64'h6000, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rpc = {32'($urandom), 32'($urandom)};
            step($urandom_range(0, 3) != 0, {rand_hw(), rand_hw()}, rpc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in the middle of traffic
        step(1, 32'h4505_4501, 64'h7000, 0, 0);
        step(1, 32'h0000_0513, 64'h7004, 0, 0);
        fetch_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        hw_q.delete(); pc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 32'h4585_4581, 64'h7100, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
